vga_text_scan: RTL and testbench

- Converts the VGA timing generator's display-enable and frame strobe into text-cell coordinates for the 40×24 Apple-1 screen.
- Fetches each character code from the video RAM and substitutes the blinking cursor glyph in the cursor cell.
- Drives the font ROM's `character`/`pixel`/`line` inputs, plus a delayed display enable aligned with the font ROM's registered pixel output.
- Sits between the timing generator/video RAM and the font ROM in the VGA path.

---
 rtl/vga_text_scan.sv | 177 +++++++++++++++++
 tb/tb_vga_text_scan.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_text_scan.sv
// Text-mode scan converter for a 40x24 character display.
// Maps VGA timing to cell coordinates, reads video RAM, drives the font ROM.
module vga_text_scan #(
  parameter int          COLS         = 40,
  parameter int          ROWS         = 24,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [5:0]  CURSOR_CHAR  = 6'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       de,
  input  logic       frame,
  input  logic [5:0] cursor_col,
  input  logic [4:0] cursor_row,
  output logic [9:0] vram_addr,
  input  logic [5:0] vram_data,
  output logic [5:0] character,
  output logic [3:0] pixel,
  output logic [4:0] line,
  output logic       de_out
);

  localparam logic [3:0] PIX_MAX  = 4'd15;
  localparam logic [4:0] LINE_MAX = 5'd19;
  localparam logic [5:0] COL_MAX  = 6'(COLS - 1);
  localparam logic [4:0] ROW_MAX  = 5'(ROWS - 1);

  localparam int BW =
    (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_MAX =
    BW'(BLINK_FRAMES - 1);

  logic [3:0]    pix_cnt;
  logic [5:0]    col;
  logic [4:0]    line_cnt;
  logic [4:0]    row;
  logic          h_over;
  logic          v_over;
  logic          de_q;
  logic [BW-1:0] blink_cnt;
  logic          blink;

  logic          de_fall;
  logic          hit;
  logic          blank;
  logic [9:0]    addr;

  logic [3:0]    s1_pix;
  logic [4:0]    s1_line;
  logic          s1_cur;
  logic          s1_vis;
  logic [3:0]    s2_pix;
  logic [4:0]    s2_line;
  logic          s2_cur;
  logic          s2_vis;
  logic          s3_vis;

  assign de_fall = de_q & ~de;

  always_ff @(posedge clk) begin
    if (rst) begin
      de_q    <= 1'b0;
      pix_cnt <= '0;
      col     <= '0;
      h_over  <= 1'b0;
    end else begin
      de_q <= de;
      if (de_fall) begin
        pix_cnt <= '0;
        col     <= '0;
        h_over  <= 1'b0;
      end else if (de) begin
        pix_cnt <= pix_cnt + 4'd1;
        if (pix_cnt == PIX_MAX) begin
          if (col == COL_MAX)
            h_over <= 1'b1;
          else
            col <= col + 6'd1;
        end
      end
    end
  end

  // frame takes priority over an end-of-line in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      line_cnt <= '0;
      row      <= '0;
      v_over   <= 1'b0;
    end else if (frame) begin
      line_cnt <= '0;
      row      <= '0;
      v_over   <= 1'b0;
    end else if (de_fall) begin
      if (line_cnt == LINE_MAX) begin
        line_cnt <= '0;
        if (row == ROW_MAX)
          v_over <= 1'b1;
        else
          row <= row + 5'd1;
      end else begin
        line_cnt <= line_cnt + 5'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (frame) begin
      if (blink_cnt == BLINK_MAX) begin
        blink_cnt <= '0;
        blink     <= ~blink;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    hit = (col == cursor_col) &&
          (row == cursor_row) &&
          (cursor_col <= COL_MAX) &&
          (cursor_row <= ROW_MAX);
    blank = h_over | v_over;
    addr  = 10'(row) * 10'(COLS) + 10'(col);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vram_addr <= '0;
      s1_pix    <= '0;
      s1_line   <= '0;
      s1_cur    <= 1'b0;
      s1_vis    <= 1'b0;
    end else begin
      vram_addr <= addr;
      s1_pix    <= pix_cnt;
      s1_line   <= line_cnt;
      s1_cur    <= hit & blink;
      s1_vis    <= de & ~blank;
    end
  end

  // stage 2: RAM read in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_pix  <= '0;
      s2_line <= '0;
      s2_cur  <= 1'b0;
      s2_vis  <= 1'b0;
    end else begin
      s2_pix  <= s1_pix;
      s2_line <= s1_line;
      s2_cur  <= s1_cur;
      s2_vis  <= s1_vis;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      character <= '0;
      pixel     <= '0;
      line      <= '0;
      s3_vis    <= 1'b0;
      de_out    <= 1'b0;
    end else begin
      character <= s2_cur ? CURSOR_CHAR : vram_data;
      pixel     <= s2_pix;
      line      <= s2_line;
      s3_vis    <= s2_vis;
      de_out    <= s3_vis;
    end
  end

endmodule

// File: tb/tb_vga_text_scan.sv
// Directed bench for vga_text_scan with a registered video RAM model.
// Expected values are derived from cycle indices and a cell-code function.
module tb_vga_text_scan;

  localparam int COLS = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic       de;
  logic       frame;
  logic [5:0] cursor_col;
  logic [4:0] cursor_row;
  logic [9:0] vram_addr;
  logic [5:0] vram_data = '0;
  logic [5:0] character;
  logic [3:0] pixel;
  logic [4:0] line;
  logic       de_out;

  int  tests = 0;
  int  fails = 0;
  int  nframes = 0;
  bit  use_const = 1'b0;
  logic [5:0] cval = 6'h01;

  vga_text_scan #(
    .COLS(40),
    .ROWS(24),
    .BLINK_FRAMES(2),
    .CURSOR_CHAR(6'h00)
  ) dut (
    .clk(clk),
    .rst(rst),
    .de(de),
    .frame(frame),
    .cursor_col(cursor_col),
    .cursor_row(cursor_row),
    .vram_addr(vram_addr),
    .vram_data(vram_data),
    .character(character),
    .pixel(pixel),
    .line(line),
    .de_out(de_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    vram_data <= use_const ? cval : (vram_addr[5:0] ^ 6'h2A);

  initial begin
    #5_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_char(
    input int r, input int c, input bit bl);
    if (use_const) begin
      if (bl && r == int'(cursor_row) &&
          c == int'(cursor_col))
        return 32'h00;
      return 32'(cval);
    end
    return 32'(((r * COLS + c) & 63) ^ 42);
  endfunction

  task automatic frame_pulse();
    frame = 1'b1;
    tick();
    frame = 1'b0;
    nframes++;
    tick();
  endtask

  task automatic short_lines(input int n);
    for (int i = 0; i < n; i++) begin
      de = 1'b1;
      tick();
      de = 1'b0;
      tick();
    end
  endtask

  task automatic burst(input int n, input int gap,
                       input int erow, input int eline,
                       input bit vis, input bit fr_fall);
    bit bl;
    int t;
    int c;
    bl = ((nframes / 2) % 2) == 1;
    for (int k = 0; k < n + gap; k++) begin
      de    = (k < n);
      frame = fr_fall && (k == n);
      tick();
      if (frame) nframes++;
      if (k < n) begin
        c = (k / 16 > 39) ? 39 : k / 16;
        chk($sformatf("addr r%0d k%0d", erow, k),
            32'(vram_addr), 32'(erow * COLS + c));
      end
      if (k >= 2 && k - 2 < n) begin
        t = k - 2;
        chk($sformatf("pixel t%0d", t),
            32'(pixel), 32'(t % 16));
        chk($sformatf("line t%0d", t),
            32'(line), 32'(eline));
        if (vis && t < 640)
          chk($sformatf("char r%0d c%0d", erow, t / 16),
              32'(character), exp_char(erow, t / 16, bl));
      end
      if (k >= 3 && k - 3 < n + 2) begin
        t = k - 3;
        chk($sformatf("de_out r%0d t%0d", erow, t),
            32'(de_out),
            32'((t < n) && vis && (t < 640)));
      end
    end
    frame = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " vram_addr"}, 32'(vram_addr), 32'h0);
    chk({tag, " character"}, 32'(character), 32'h0);
    chk({tag, " pixel"}, 32'(pixel), 32'h0);
    chk({tag, " line"}, 32'(line), 32'h0);
    chk({tag, " de_out"}, 32'(de_out), 32'h0);
  endtask

  initial begin
    rst        = 1'b1;
    de         = 1'b0;
    frame      = 1'b0;
    cursor_col = 6'd63;
    cursor_row = 5'd31;
    repeat (3) tick();
    chk_zero("reset");
    rst = 1'b0;
    tick();

    // address walk followed by line/row wrap
    frame_pulse();
    for (int l = 0; l <= 20; l++)
      burst(640, 160, l / 20, l % 20, 1'b1, 1'b0);
    short_lines(458);
    burst(640, 160, 23, 19, 1'b1, 1'b0);
    burst(640, 160, 23, 0, 1'b0, 1'b0);

    // overscan with an out-of-range cursor while blink is on
    cursor_col = 6'd40;
    cursor_row = 5'd0;
    frame_pulse();
    burst(700, 100, 0, 0, 1'b1, 1'b0);

    // frame coincides with an end-of-line at row 1, line 5
    short_lines(24);
    de = 1'b1;
    tick();
    de    = 1'b0;
    frame = 1'b1;
    tick();
    frame = 1'b0;
    nframes++;
    repeat (4) tick();
    burst(640, 40, 0, 0, 1'b1, 1'b0);

    // cursor blink at cell (5,2)
    use_const  = 1'b1;
    cval       = 6'h01;
    cursor_col = 6'd5;
    cursor_row = 5'd2;
    for (int f = 0; f < 4; f++) begin
      frame_pulse();
      short_lines(40);
      burst(640, 40, 2, 0, 1'b1, 1'b0);
    end

    // reset in the middle of a line
    use_const = 1'b0;
    frame_pulse();
    for (int k = 0; k < 300; k++) begin
      de = 1'b1;
      tick();
    end
    rst = 1'b1;
    tick();
    chk_zero("mid-reset");
    rst = 1'b0;
    de  = 1'b0;
    nframes = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("post-reset de_out %0d", i),
          32'(de_out), 32'h0);
    end
    burst(640, 40, 0, 0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
